// File: rtl/spi_duty_receiver_pkg.sv
// Shared constants and types for the SPI duty-command receiver.
package spi_duty_receiver_pkg;

  localparam int unsigned DUTY_W     = 4;
  localparam int unsigned MAX_DUTY   = 10;
  localparam int unsigned FRAME_BITS = 8;
  localparam int unsigned CNT_W      = 4;
  localparam logic [3:0]  CMD_SET    = 4'hA;
  localparam logic [3:0]  CMD_READ   = 4'h5;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    CHECK
  } state_t;

endpackage

// File: rtl/spi_duty_receiver_if.sv
// SPI pin bundle between an external MCU (master) and the duty receiver (slave).
interface spi_duty_receiver_if;

  logic SCK;
  logic MOSI;
  logic CS_N;
  logic MISO;

  modport master (output SCK, output MOSI, output CS_N, input MISO);
  modport slave  (input SCK, input MOSI, input CS_N, output MISO);

endinterface

// File: rtl/spi_duty_receiver_sync_edge.sv
// Multi-flop synchronizer for one asynchronous pin, with registered
// rise/fall pulses aligned to the delayed level output.
module spi_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   dly_q;

  // Synchronizer chain, delay flop and edge pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      dly_q  <= RESET_VAL;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q[0] <= din;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      dly_q <= sync_q[SYNC_STAGES-1];
      rise  <= sync_q[SYNC_STAGES-1] & ~dly_q;
      fall  <= ~sync_q[SYNC_STAGES-1] & dly_q;
    end
  end

  assign level = dly_q;

endmodule

// File: rtl/spi_duty_receiver.sv
// SPI mode-0 slave that receives 8-bit duty commands, validates them and
// holds the accepted duty for the PWM stage. Everything runs on SLK.
module spi_duty_receiver #(
  parameter int unsigned DUTY_W      = spi_duty_receiver_pkg::DUTY_W,
  parameter int unsigned MAX_DUTY    = spi_duty_receiver_pkg::MAX_DUTY,
  parameter int unsigned RESET_DUTY  = 0,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [3:0]  CMD_SET     = spi_duty_receiver_pkg::CMD_SET,
  parameter logic [3:0]  CMD_READ    = spi_duty_receiver_pkg::CMD_READ
) (
  input  logic                    SLK,
  input  logic                    RST_N,
  spi_duty_receiver_if.slave      spi,
  output logic [DUTY_W-1:0]       duty,
  output logic                    duty_upd,
  output logic                    frame_err
);

  import spi_duty_receiver_pkg::*;

  localparam logic [DUTY_W-1:0] MAX_V     = DUTY_W'(MAX_DUTY);
  localparam logic [DUTY_W-1:0] RST_V     = DUTY_W'(RESET_DUTY);
  localparam logic [CNT_W-1:0]  FRAME_CNT = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0]  CNT_SAT   = CNT_W'(FRAME_BITS + 1);

  logic sck_level_unused, sck_rise, sck_fall;
  logic mosi_level, mosi_rise_unused, mosi_fall_unused;
  logic cs_level, cs_rise, cs_fall;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
    .clk(SLK), .rst_n(RST_N), .din(spi.SCK),
    .level(sck_level_unused), .rise(sck_rise), .fall(sck_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(SLK), .rst_n(RST_N), .din(spi.MOSI),
    .level(mosi_level), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk(SLK), .rst_n(RST_N), .din(spi.CS_N),
    .level(cs_level), .rise(cs_rise), .fall(cs_fall)
  );

  state_t state_q, state_d;
  logic   pend_q, pend_d;

  logic [CNT_W-1:0]      bit_cnt_q;
  logic [FRAME_BITS-1:0] rx_q, tx_q, tx_load;
  logic                  miso_q;

  logic load_frame, sample_bit, shift_tx, eval;
  logic [3:0]        cmd;
  logic [DUTY_W-1:0] val;
  logic              set_ok, reject;

  assign tx_load = FRAME_BITS'(duty);
  assign cmd     = rx_q[FRAME_BITS-1 -: 4];
  assign val     = rx_q[DUTY_W-1:0];

  // FSM state and pending-start register.
  always_ff @(posedge SLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

  // Next state and datapath strobes; a CS_N rise beats any same-cycle SCK edge.
  always_comb begin
    state_d    = state_q;
    pend_d     = 1'b0;
    load_frame = 1'b0;
    sample_bit = 1'b0;
    shift_tx   = 1'b0;
    eval       = 1'b0;
    case (state_q)
      IDLE: begin
        // A CS_N fall seen during CHECK is replayed here if CS_N is still low.
        if (cs_fall || (pend_q && !cs_level)) begin
          state_d    = SHIFT;
          load_frame = 1'b1;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          state_d = CHECK;
        end else begin
          sample_bit = sck_rise;
          shift_tx   = sck_fall;
        end
      end
      CHECK: begin
        state_d = IDLE;
        eval    = 1'b1;
        pend_d  = cs_fall;
      end
      default: state_d = IDLE;
    endcase
  end

  // Frame evaluation in CHECK.
  always_comb begin
    set_ok = 1'b0;
    reject = 1'b0;
    if (eval) begin
      if (bit_cnt_q != FRAME_CNT) begin
        reject = 1'b1;
      end else if (cmd == CMD_SET) begin
        if (val <= MAX_V) set_ok = 1'b1;
        else              reject = 1'b1;
      end else if (cmd != CMD_READ) begin
        reject = 1'b1;
      end
    end
  end

  // Shift registers, bit counter, MISO and the held duty value.
  always_ff @(posedge SLK or negedge RST_N) begin
    if (!RST_N) begin
      bit_cnt_q <= '0;
      rx_q      <= '0;
      tx_q      <= '0;
      miso_q    <= 1'b0;
      duty      <= RST_V;
      duty_upd  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      duty_upd  <= set_ok;
      frame_err <= reject;
      if (set_ok) duty <= val;

      if (load_frame) begin
        bit_cnt_q <= '0;
        rx_q      <= '0;
        tx_q      <= tx_load;
      end
      if (sample_bit) begin
        rx_q <= {rx_q[FRAME_BITS-2:0], mosi_level};
        if (bit_cnt_q != CNT_SAT) bit_cnt_q <= bit_cnt_q + CNT_W'(1);
      end
      if (shift_tx) tx_q <= {tx_q[FRAME_BITS-2:0], 1'b0};

      if (state_d != SHIFT)   miso_q <= 1'b0;
      else if (load_frame)    miso_q <= tx_load[FRAME_BITS-1];
      else if (shift_tx)      miso_q <= tx_q[FRAME_BITS-2];
    end
  end

  assign spi.MISO = miso_q;

endmodule

// File: tb/tb_spi_duty_receiver.sv
// Directed bench for spi_duty_receiver: SPI mode 0 frames at SCK = SLK/8.
module tb_spi_duty_receiver;

  localparam int HALF = 4;

  logic       SLK = 1'b0;
  logic       RST_N;
  logic [3:0] duty;
  logic       duty_upd;
  logic       frame_err;

  int checks   = 0;
  int failures = 0;
  int upd_cnt  = 0;
  int err_cnt  = 0;
  logic [3:0] upd_vals[$];

  spi_duty_receiver_if spi();

  spi_duty_receiver #(
    .DUTY_W(4), .MAX_DUTY(10), .RESET_DUTY(0), .SYNC_STAGES(2),
    .CMD_SET(4'hA), .CMD_READ(4'h5)
  ) dut (
    .SLK(SLK), .RST_N(RST_N), .spi(spi),
    .duty(duty), .duty_upd(duty_upd), .frame_err(frame_err)
  );

  always #5 SLK = ~SLK;

  always @(negedge SLK) begin
    if (duty_upd === 1'b1) begin
      upd_cnt++;
      upd_vals.push_back(duty);
    end
    if (frame_err === 1'b1) err_cnt++;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge SLK);
    #1;
  endtask

  task automatic spi_xfer(input logic [15:0] data, input int nbits, output logic [15:0] miso_bits);
    miso_bits = '0;
    spi.SCK  = 1'b0;
    spi.CS_N = 1'b0;
    for (int i = nbits - 1; i >= 0; i--) begin
      spi.MOSI = data[i];
      wait_clk(HALF);
      miso_bits = {miso_bits[14:0], spi.MISO};
      spi.SCK = 1'b1;
      wait_clk(HALF);
      spi.SCK = 1'b0;
    end
    wait_clk(HALF);
    spi.CS_N = 1'b1;
    spi.MOSI = 1'b0;
  endtask

  task automatic test_reset();
    RST_N = 1'b0; spi.CS_N = 1'b1; spi.SCK = 1'b0; spi.MOSI = 1'b0;
    wait_clk(3);
    checks++; if (duty !== 4'd0) begin failures++; $display("FAIL reset_duty: got %0d expected 0", duty); end
    checks++; if (duty_upd !== 1'b0) begin failures++; $display("FAIL reset_upd: got %b expected 0", duty_upd); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b expected 0", frame_err); end
    checks++; if (spi.MISO !== 1'b0) begin failures++; $display("FAIL reset_miso: got %b expected 0", spi.MISO); end
    RST_N = 1'b1;
    wait_clk(5);
  endtask

  task automatic test_legal_write();
    logic [15:0] m;
    int u0, e0;
    u0 = upd_cnt; e0 = err_cnt;
    spi_xfer(16'h00A7, 8, m);
    for (int i = 1; i <= 6; i++) begin
      wait_clk(1);
      if (i == 4) begin
        checks++; if (duty !== 4'd0) begin failures++; $display("FAIL lat_early_duty: got %0d expected 0", duty); end
      end
      if (i == 5) begin
        checks++; if (duty !== 4'd7) begin failures++; $display("FAIL lat_duty: got %0d expected 7", duty); end
        checks++; if (duty_upd !== 1'b1) begin failures++; $display("FAIL lat_upd: got %b expected 1", duty_upd); end
      end
      if (i == 6) begin
        checks++; if (duty_upd !== 1'b0) begin failures++; $display("FAIL upd_width: got %b expected 0", duty_upd); end
      end
    end
    wait_clk(4);
    checks++; if (upd_cnt - u0 !== 1) begin failures++; $display("FAIL a7_upd_count: got %0d expected 1", upd_cnt - u0); end
    spi_xfer(16'h00AA, 8, m);
    wait_clk(8);
    checks++; if (duty !== 4'd10) begin failures++; $display("FAIL aa_duty: got %0d expected 10", duty); end
    checks++; if (upd_cnt - u0 !== 2) begin failures++; $display("FAIL aa_upd_count: got %0d expected 2", upd_cnt - u0); end
    checks++; if (err_cnt - e0 !== 0) begin failures++; $display("FAIL legal_err_count: got %0d expected 0", err_cnt - e0); end
  endtask

  task automatic test_reset_mid_frame();
    logic [15:0] m;
    logic [3:0]  b;
    int u0;
    u0 = upd_cnt;
    b  = 4'b1010;
    spi.SCK = 1'b0; spi.CS_N = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      spi.MOSI = b[i];
      wait_clk(HALF);
      spi.SCK = 1'b1;
      wait_clk(HALF);
      spi.SCK = 1'b0;
    end
    spi.MOSI = 1'b1; wait_clk(HALF); spi.SCK = 1'b1;
    RST_N = 1'b0;
    #2;
    checks++; if (duty !== 4'd0) begin failures++; $display("FAIL midrst_duty: got %0d expected 0", duty); end
    checks++; if (spi.MISO !== 1'b0) begin failures++; $display("FAIL midrst_miso: got %b expected 0", spi.MISO); end
    checks++; if (duty_upd !== 1'b0) begin failures++; $display("FAIL midrst_upd: got %b expected 0", duty_upd); end
    spi.SCK = 1'b0; spi.CS_N = 1'b1; spi.MOSI = 1'b0;
    wait_clk(3);
    RST_N = 1'b1;
    wait_clk(5);
    checks++; if (upd_cnt - u0 !== 0) begin failures++; $display("FAIL midrst_upd_count: got %0d expected 0", upd_cnt - u0); end
    spi_xfer(16'h00A3, 8, m);
    wait_clk(8);
    checks++; if (duty !== 4'd3) begin failures++; $display("FAIL post_rst_duty: got %0d expected 3", duty); end
    checks++; if (upd_cnt - u0 !== 1) begin failures++; $display("FAIL post_rst_upd_count: got %0d expected 1", upd_cnt - u0); end
  endtask

  task automatic test_out_of_range();
    logic [15:0] m;
    int u0, e0;
    spi_xfer(16'h00A5, 8, m);
    wait_clk(8);
    checks++; if (duty !== 4'd5) begin failures++; $display("FAIL a5_duty: got %0d expected 5", duty); end
    u0 = upd_cnt; e0 = err_cnt;
    spi_xfer(16'h00AB, 8, m);
    wait_clk(8);
    checks++; if (duty !== 4'd5) begin failures++; $display("FAIL ab_duty: got %0d expected 5", duty); end
    checks++; if (err_cnt - e0 !== 1) begin failures++; $display("FAIL ab_err_count: got %0d expected 1", err_cnt - e0); end
    spi_xfer(16'h0035, 8, m);
    wait_clk(8);
    checks++; if (duty !== 4'd5) begin failures++; $display("FAIL cmd3_duty: got %0d expected 5", duty); end
    checks++; if (err_cnt - e0 !== 2) begin failures++; $display("FAIL cmd3_err_count: got %0d expected 2", err_cnt - e0); end
    checks++; if (upd_cnt - u0 !== 0) begin failures++; $display("FAIL oor_upd_count: got %0d expected 0", upd_cnt - u0); end
  endtask

  task automatic test_short_long();
    logic [15:0] m;
    int u0, e0;
    u0 = upd_cnt; e0 = err_cnt;
    spi_xfer(16'h0052, 7, m);
    wait_clk(8);
    checks++; if (err_cnt - e0 !== 1) begin failures++; $display("FAIL short_err_count: got %0d expected 1", err_cnt - e0); end
    checks++; if (duty !== 4'd5) begin failures++; $display("FAIL short_duty: got %0d expected 5", duty); end
    spi_xfer(16'h00A4, 9, m);
    wait_clk(8);
    checks++; if (err_cnt - e0 !== 2) begin failures++; $display("FAIL long_err_count: got %0d expected 2", err_cnt - e0); end
    checks++; if (duty !== 4'd5) begin failures++; $display("FAIL long_duty: got %0d expected 5", duty); end
    checks++; if (upd_cnt - u0 !== 0) begin failures++; $display("FAIL shortlong_upd_count: got %0d expected 0", upd_cnt - u0); end
  endtask

  task automatic test_readback();
    logic [15:0] m;
    int u0, e0;
    spi_xfer(16'h00A6, 8, m);
    wait_clk(8);
    checks++; if (duty !== 4'd6) begin failures++; $display("FAIL a6_duty: got %0d expected 6", duty); end
    u0 = upd_cnt; e0 = err_cnt;
    spi_xfer(16'h0050, 8, m);
    checks++; if (m[7:0] !== 8'h06) begin failures++; $display("FAIL read_miso: got %b expected 00000110", m[7:0]); end
    wait_clk(8);
    checks++; if (duty !== 4'd6) begin failures++; $display("FAIL read_duty: got %0d expected 6", duty); end
    checks++; if (upd_cnt - u0 !== 0) begin failures++; $display("FAIL read_upd_count: got %0d expected 0", upd_cnt - u0); end
    checks++; if (err_cnt - e0 !== 0) begin failures++; $display("FAIL read_err_count: got %0d expected 0", err_cnt - e0); end
    checks++; if (spi.MISO !== 1'b0) begin failures++; $display("FAIL idle_miso: got %b expected 0", spi.MISO); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] m;
    int u0, e0, n;
    u0 = upd_cnt; e0 = err_cnt;
    spi_xfer(16'h00A2, 8, m);
    wait_clk(2);
    spi_xfer(16'h00A9, 8, m);
    wait_clk(8);
    n = upd_vals.size();
    checks++; if (upd_cnt - u0 !== 2) begin failures++; $display("FAIL b2b_upd_count: got %0d expected 2", upd_cnt - u0); end
    checks++; if (err_cnt - e0 !== 0) begin failures++; $display("FAIL b2b_err_count: got %0d expected 0", err_cnt - e0); end
    if (n >= 2) begin
      checks++; if (upd_vals[n-2] !== 4'd2) begin failures++; $display("FAIL b2b_first: got %0d expected 2", upd_vals[n-2]); end
    end else begin
      checks++; failures++; $display("FAIL b2b_history: got %0d entries expected at least 2", n);
    end
    checks++; if (duty !== 4'd9) begin failures++; $display("FAIL b2b_duty: got %0d expected 9", duty); end
  endtask

  initial begin
    spi.SCK = 1'b0; spi.MOSI = 1'b0; spi.CS_N = 1'b1; RST_N = 1'b0;
    test_reset();
    test_legal_write();
    test_reset_mid_frame();
    test_out_of_range();
    test_short_long();
    test_readback();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
